power_drive_ctrl: RTL and testbench

// Power and manual-drive sequencer for the car simulator top level.

---
 rtl/power_drive_ctrl_if.sv | 40 ++++
 rtl/power_drive_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_power_drive_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/power_drive_ctrl_if.sv
// Interface bundling the operator controls and simulator/board outputs of
// power_drive_ctrl.
//   master : drives the buttons, switches and pedals, observes the outputs
//   slave  : the sequencer itself (samples inputs, drives outputs)
interface power_drive_ctrl_if;
  logic       power_btn;
  logic [1:0] mode_selection;
  logic       throttle;
  logic       clutch;
  logic       brake;
  logic       move_backward;
  logic       turn_left;
  logic       turn_right;

  logic       power_state;
  logic [1:0] mode;
  logic [1:0] drive_state;
  logic       move_forward_signal;
  logic       move_backward_signal;
  logic       turn_left_signal;
  logic       turn_right_signal;
  logic       turn_left_light;
  logic       turn_right_light;

  modport master (
    output power_btn, mode_selection, throttle, clutch, brake,
           move_backward, turn_left, turn_right,
    input  power_state, mode, drive_state, move_forward_signal,
           move_backward_signal, turn_left_signal, turn_right_signal,
           turn_left_light, turn_right_light
  );

  modport slave (
    input  power_btn, mode_selection, throttle, clutch, brake,
           move_backward, turn_left, turn_right,
    output power_state, mode, drive_state, move_forward_signal,
           move_backward_signal, turn_left_signal, turn_right_signal,
           turn_left_light, turn_right_light
  );
endinterface

// File: rtl/power_drive_ctrl.sv
// Power and manual-drive sequencer for the car simulator.
//   clk, rst : 100 MHz clock, synchronous active-high reset
//   bus      : power_drive_ctrl_if.slave
//              inputs  power_btn, mode_selection, throttle, clutch, brake,
//                      move_backward, turn_left, turn_right
//              outputs power_state, mode, drive_state, move_*_signal,
//                      turn_*_signal, turn_*_light
// Long press powers on, a fresh press powers off, the manual-drive FSM
// (NOT_STARTING / STARTING / MOVING) runs in mode 01, and the turn lamps blink
// in any mode while powered.
module power_drive_ctrl #(
  parameter int LONG_PRESS_CYC = 100_000_000,
  parameter int BLINK_CYC      = 50_000_000
) (
  input logic               clk,
  input logic               rst,
  power_drive_ctrl_if.slave bus
);
  localparam int PW = $clog2(LONG_PRESS_CYC);
  localparam int BW = $clog2(BLINK_CYC);
  localparam logic [PW-1:0] PRESS_LAST  = PW'(LONG_PRESS_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYC - 1);
  localparam logic [1:0]    MODE_MANUAL = 2'b01;

  typedef enum logic [1:0] {
    NOT_STARTING = 2'b00,
    STARTING     = 2'b01,
    MOVING       = 2'b10
  } drive_t;

  logic          power_reg, power_next;
  logic          armed_reg, armed_next;
  logic          btn_prev_reg;
  logic [PW-1:0] press_cnt_reg, press_cnt_next;
  logic [1:0]    mode_reg, mode_next;
  drive_t        drive_reg, drive_next;
  logic          gear_reg, gear_next;
  logic          go_off;

  logic          fwd_reg, fwd_next;
  logic          bwd_reg, bwd_next;
  logic          tls_reg, tls_next;
  logic          trs_reg, trs_next;
  logic          left_light_reg, left_light_next;
  logic          right_light_reg, right_light_next;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          blink_on_reg, blink_on_next;
  logic          blink_side_reg, blink_side_next;   // 0 left, 1 right

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      power_reg       <= 1'b0;
      armed_reg       <= 1'b0;
      btn_prev_reg    <= 1'b0;
      press_cnt_reg   <= '0;
      mode_reg        <= 2'b00;
      drive_reg       <= NOT_STARTING;
      gear_reg        <= 1'b0;
      fwd_reg         <= 1'b0;
      bwd_reg         <= 1'b0;
      tls_reg         <= 1'b0;
      trs_reg         <= 1'b0;
      left_light_reg  <= 1'b0;
      right_light_reg <= 1'b0;
      blink_cnt_reg   <= '0;
      blink_on_reg    <= 1'b0;
      blink_side_reg  <= 1'b0;
    end else begin
      power_reg       <= power_next;
      armed_reg       <= armed_next;
      btn_prev_reg    <= bus.power_btn;
      press_cnt_reg   <= press_cnt_next;
      mode_reg        <= mode_next;
      drive_reg       <= drive_next;
      gear_reg        <= gear_next;
      fwd_reg         <= fwd_next;
      bwd_reg         <= bwd_next;
      tls_reg         <= tls_next;
      trs_reg         <= trs_next;
      left_light_reg  <= left_light_next;
      right_light_reg <= right_light_next;
      blink_cnt_reg   <= blink_cnt_next;
      blink_on_reg    <= blink_on_next;
      blink_side_reg  <= blink_side_next;
    end
  end

  // Next-state: power sequencing, mode latch, drive FSM
  always_comb begin
    power_next     = power_reg;
    armed_next     = armed_reg;
    press_cnt_next = press_cnt_reg;
    mode_next      = mode_reg;
    drive_next     = drive_reg;
    gear_next      = gear_reg;
    go_off         = 1'b0;

    if (!power_reg) begin
      armed_next = 1'b0;
      if (bus.power_btn) begin
        // Saturate at the last count; power comes up on this edge.
        if (press_cnt_reg == PRESS_LAST) power_next = 1'b1;
        else press_cnt_next = press_cnt_reg + 1'b1;
      end else begin
        press_cnt_next = '0;
      end
    end else begin
      press_cnt_next = '0;
      // The press that powered us on must be released before a new press counts.
      if (!bus.power_btn) armed_next = 1'b1;
      if (armed_reg && bus.power_btn && !btn_prev_reg) go_off = 1'b1;

      if (mode_reg == MODE_MANUAL) begin
        case (drive_reg)
          NOT_STARTING: begin
            if (bus.throttle && !bus.clutch) go_off = 1'b1;            // stall
            else if (bus.brake) drive_next = NOT_STARTING;
            else if (bus.throttle && bus.clutch) drive_next = STARTING;
          end
          STARTING: begin
            gear_next = bus.move_backward;
            if (bus.brake) drive_next = NOT_STARTING;
            else if (bus.throttle && !bus.clutch) drive_next = MOVING;
          end
          MOVING: begin
            // Changing gear without the clutch stalls the engine.
            if ((bus.move_backward != gear_reg) && !bus.clutch) go_off = 1'b1;
            else if (bus.brake) drive_next = NOT_STARTING;
            else if (bus.clutch || !bus.throttle) drive_next = STARTING;
          end
          default: drive_next = NOT_STARTING;
        endcase
      end else begin
        drive_next = NOT_STARTING;
      end

      if (drive_reg == NOT_STARTING) mode_next = bus.mode_selection;

      if (go_off) begin
        power_next = 1'b0;
        armed_next = 1'b0;
        mode_next  = 2'b00;
        drive_next = NOT_STARTING;
        gear_next  = 1'b0;
      end
    end
  end

  // Output logic: next values of the registered signals and lamps
  always_comb begin
    fwd_next         = 1'b0;
    bwd_next         = 1'b0;
    tls_next         = 1'b0;
    trs_next         = 1'b0;
    left_light_next  = 1'b0;
    right_light_next = 1'b0;
    blink_cnt_next   = '0;
    blink_on_next    = 1'b0;
    blink_side_next  = blink_side_reg;

    if (power_reg && !go_off) begin
      fwd_next = (drive_reg == MOVING) && !gear_reg;
      bwd_next = (drive_reg == MOVING) && gear_reg;
      if ((mode_reg == MODE_MANUAL) && (drive_reg != NOT_STARTING)) begin
        tls_next = bus.turn_left && !bus.turn_right;
        trs_next = bus.turn_right && !bus.turn_left;
      end

      if (bus.turn_left ^ bus.turn_right) begin
        blink_on_next = 1'b1;
        if (!blink_on_reg || (blink_side_reg != bus.turn_right)) begin
          // New or switched side: restart phase with the lamp lit.
          blink_side_next  = bus.turn_right;
          left_light_next  = !bus.turn_right;
          right_light_next = bus.turn_right;
        end else if (blink_cnt_reg == BLINK_LAST) begin
          left_light_next  = blink_side_reg ? 1'b0 : !left_light_reg;
          right_light_next = blink_side_reg ? !right_light_reg : 1'b0;
        end else begin
          blink_cnt_next   = blink_cnt_reg + 1'b1;
          left_light_next  = left_light_reg;
          right_light_next = right_light_reg;
        end
      end
    end
  end

  assign bus.power_state          = power_reg;
  assign bus.mode                 = mode_reg;
  assign bus.drive_state          = drive_reg;
  assign bus.move_forward_signal  = fwd_reg;
  assign bus.move_backward_signal = bwd_reg;
  assign bus.turn_left_signal     = tls_reg;
  assign bus.turn_right_signal    = trs_reg;
  assign bus.turn_left_light      = left_light_reg;
  assign bus.turn_right_light     = right_light_reg;
endmodule

// File: tb/tb_power_drive_ctrl.sv
// Scoreboard bench for power_drive_ctrl (LONG_PRESS_CYC=10, BLINK_CYC=4).
// Stimulus pushes expected output values; a negedge monitor pops and compares.
module tb_power_drive_ctrl;
  localparam int S_POWER = 0, S_MODE = 1, S_DRIVE = 2, S_FWD = 3, S_BWD = 4,
                 S_TLS = 5, S_TRS = 6, S_TLL = 7, S_TRL = 8;

  typedef struct {
    string      name;
    int         sig;
    logic [1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];
  exp_t cur;

  power_drive_ctrl_if bus();

  power_drive_ctrl #(.LONG_PRESS_CYC(10), .BLINK_CYC(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] actual(input int sig);
    case (sig)
      S_POWER: return {1'b0, bus.power_state};
      S_MODE:  return bus.mode;
      S_DRIVE: return bus.drive_state;
      S_FWD:   return {1'b0, bus.move_forward_signal};
      S_BWD:   return {1'b0, bus.move_backward_signal};
      S_TLS:   return {1'b0, bus.turn_left_signal};
      S_TRS:   return {1'b0, bus.turn_right_signal};
      S_TLL:   return {1'b0, bus.turn_left_light};
      default: return {1'b0, bus.turn_right_light};
    endcase
  endfunction

  // Monitor: the DUT presents its outputs every cycle; compare at negedge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      n_vec++;
      if (actual(cur.sig) !== cur.val) begin
        n_miss++;
        $display("FAIL %s: got %0h, expected %0h at %0t", cur.name,
                 actual(cur.sig), cur.val, $time);
      end else begin
        $display("ok   %s = %0h", cur.name, cur.val);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int sig, input logic [1:0] val);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic power_on();
    bus.power_btn = 1'b1;
    step(10);
    chk("power_on", S_POWER, 2'd1);
    bus.power_btn = 1'b0;
    step(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bus.power_btn = 1'b0; bus.mode_selection = 2'b00; bus.throttle = 1'b0;
    bus.clutch = 1'b0; bus.brake = 1'b0; bus.move_backward = 1'b0;
    bus.turn_left = 1'b0; bus.turn_right = 1'b0;

    // Reset state
    step(3);
    chk("rst_power", S_POWER, 2'd0);
    chk("rst_mode", S_MODE, 2'd0);
    chk("rst_drive", S_DRIVE, 2'd0);
    chk("rst_fwd", S_FWD, 2'd0);
    chk("rst_tll", S_TLL, 2'd0);
    chk("rst_trl", S_TRL, 2'd0);
    rst = 1'b0;

    // 9-cycle press is too short
    bus.power_btn = 1'b1;
    step(9);
    bus.power_btn = 1'b0;
    step(1);
    chk("short_press_off", S_POWER, 2'd0);
    step(1);

    // 10-cycle press powers on; holding does not power off
    bus.power_btn = 1'b1;
    step(9);
    chk("press9_still_off", S_POWER, 2'd0);
    step(1);
    chk("press10_on", S_POWER, 2'd1);
    bus.mode_selection = 2'b01;
    step(5);
    chk("held_stays_on", S_POWER, 2'd1);
    chk("mode_latched", S_MODE, 2'd1);
    bus.power_btn = 1'b0;
    step(2);
    bus.power_btn = 1'b1;
    step(1);
    chk("press_off_power", S_POWER, 2'd0);
    chk("press_off_mode", S_MODE, 2'd0);
    bus.power_btn = 1'b0;
    step(1);

    // Manual drive: STARTING -> MOVING forward
    power_on();
    chk("man_mode", S_MODE, 2'd1);
    chk("man_ns", S_DRIVE, 2'd0);
    bus.throttle = 1'b1; bus.clutch = 1'b1;
    step(1);
    chk("to_starting", S_DRIVE, 2'd1);
    bus.clutch = 1'b0;
    step(1);
    chk("to_moving", S_DRIVE, 2'd2);
    chk("fwd_lag", S_FWD, 2'd0);
    step(1);
    chk("fwd_on", S_FWD, 2'd1);
    chk("bwd_off", S_BWD, 2'd0);
    bus.turn_left = 1'b1;
    step(2);
    chk("turn_left_sig", S_TLS, 2'd1);
    chk("turn_right_sig", S_TRS, 2'd0);
    bus.turn_left = 1'b0;
    bus.mode_selection = 2'b11;
    step(1);
    chk("mode_held_moving", S_MODE, 2'd1);
    bus.mode_selection = 2'b01;
    bus.brake = 1'b1;
    step(1);
    chk("brake_ns", S_DRIVE, 2'd0);
    step(1);
    chk("brake_fwd_off", S_FWD, 2'd0);
    bus.brake = 1'b0; bus.throttle = 1'b0; bus.clutch = 1'b0;
    step(1);

    // Stall from NOT_STARTING
    bus.throttle = 1'b1;
    step(1);
    chk("stall_ns_power", S_POWER, 2'd0);
    chk("stall_ns_mode", S_MODE, 2'd0);
    bus.throttle = 1'b0;
    step(1);

    // Gear change without clutch while MOVING stalls
    power_on();
    bus.throttle = 1'b1; bus.clutch = 1'b1;
    step(1);
    bus.clutch = 1'b0;
    step(2);
    chk("fwd_before_stall", S_FWD, 2'd1);
    bus.move_backward = 1'b1;
    step(1);
    chk("gear_stall_power", S_POWER, 2'd0);
    chk("gear_stall_fwd", S_FWD, 2'd0);
    bus.move_backward = 1'b0; bus.throttle = 1'b0;
    step(1);

    // Gear change with clutch: back to STARTING, then reverse
    power_on();
    bus.throttle = 1'b1; bus.clutch = 1'b1;
    step(1);
    bus.clutch = 1'b0;
    step(2);
    bus.clutch = 1'b1; bus.move_backward = 1'b1;
    step(1);
    chk("clutch_starting", S_DRIVE, 2'd1);
    chk("clutch_power", S_POWER, 2'd1);
    step(1);
    bus.clutch = 1'b0;
    step(1);
    chk("rev_moving", S_DRIVE, 2'd2);
    step(1);
    chk("rev_bwd", S_BWD, 2'd1);
    chk("rev_fwd", S_FWD, 2'd0);
    bus.brake = 1'b1;
    step(1);
    chk("rev_brake", S_DRIVE, 2'd0);
    bus.brake = 1'b0; bus.throttle = 1'b0; bus.clutch = 1'b0; bus.move_backward = 1'b0;
    bus.power_btn = 1'b1;
    step(1);
    chk("rev_off", S_POWER, 2'd0);
    bus.power_btn = 1'b0;
    step(1);

    // Turn lamps in semi-auto mode
    bus.mode_selection = 2'b10;
    power_on();
    chk("semi_mode", S_MODE, 2'd2);
    bus.turn_left = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk($sformatf("left_blink_%0d", i), S_TLL, ((i / 4) % 2 == 0) ? 2'd1 : 2'd0);
    end
    chk("left_blink_right_off", S_TRL, 2'd0);
    chk("semi_no_turn_sig", S_TLS, 2'd0);
    bus.turn_right = 1'b1;
    step(1);
    chk("both_left_off", S_TLL, 2'd0);
    chk("both_right_off", S_TRL, 2'd0);
    bus.turn_left = 1'b0;
    step(1);
    chk("right_only_on", S_TRL, 2'd1);
    chk("right_only_left", S_TLL, 2'd0);
    bus.turn_right = 1'b0; bus.turn_left = 1'b1;
    step(1);
    chk("switch_left_on", S_TLL, 2'd1);
    chk("switch_right_off", S_TRL, 2'd0);
    bus.turn_left = 1'b0;
    step(1);
    chk("none_left_off", S_TLL, 2'd0);

    step(2);
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
